// File: rtl/cfg_slice_alu_pipe.sv
// Two-stage valid/ready slice ALU: stage A latches operands with per-bit P/G,
// stage B ripples the carry and registers the result with chained carry/zero/ones flags.
module cfg_slice_alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_cin,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_gp,
  output logic             out_last
);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_PASSA = 3'd5;
  localparam logic [2:0] OP_INC   = 3'd6;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);
  endfunction

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_PASSA: return a;
      default:  return ~a;
    endcase
  endfunction

  // carries[i] is the carry into bit i; carries[WIDTH] is the carry out
  function automatic logic [WIDTH:0] ripple(input logic [WIDTH-1:0] p,
                                            input logic [WIDTH-1:0] g,
                                            input logic cin);
    logic [WIDTH:0] c;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return c;
  endfunction

  logic             vld_p0, fresh, chain_c;
  logic [WIDTH-1:0] a_p0, b_p0, p_p0, g_p0;
  logic [2:0]       op_p0;
  logic             cin_p0, first_p0, last_p0;
  logic [WIDTH-1:0] b_eff, res_nx;
  logic [WIDTH:0]   carries;
  logic             accept, xfer, arith_p0, cin_sel;

  assign xfer     = vld_p0 & (~out_valid | out_ready);
  assign in_ready = ~vld_p0 | xfer;
  assign accept   = in_valid & in_ready;

  always_comb begin
    b_eff = in_b;
    if (in_op == OP_SUB) b_eff = ~in_b;
    else if (in_op == OP_INC) b_eff = '0;
  end

  // ---- stage A: operand and propagate/generate register ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0     <= in_a;
      b_p0     <= in_b;
      op_p0    <= in_op;
      cin_p0   <= in_cin;
      first_p0 <= in_first | fresh;
      last_p0  <= in_last;
      p_p0     <= in_a ^ b_eff;
      g_p0     <= in_a & b_eff;
    end
  end

  assign arith_p0 = is_arith(op_p0);
  assign cin_sel  = first_p0 ? ((op_p0 == OP_ADD) ? cin_p0 : 1'b1) : chain_c;
  assign carries  = ripple(p_p0, g_p0, cin_sel);
  assign res_nx   = arith_p0 ? (p_p0 ^ carries[WIDTH-1:0]) : logic_op(op_p0, a_p0, b_p0);

  // ---- stage B: result and flag register; out_zero/out_ones double as chain accumulators ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      fresh     <= 1'b1;
      chain_c   <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_ones  <= 1'b0;
      out_gp    <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        vld_p0 <= 1'b1;
        fresh  <= 1'b0;
      end else if (xfer) begin
        vld_p0 <= 1'b0;
      end
      if (xfer) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (xfer) begin
        out_res  <= res_nx;
        out_cout <= arith_p0 & carries[WIDTH];
        out_ovf  <= arith_p0 & (carries[WIDTH] ^ carries[WIDTH-1]);
        out_zero <= (res_nx == '0) & (first_p0 | out_zero);
        out_ones <= (&res_nx) & (first_p0 | out_ones);
        out_gp   <= arith_p0 & (&p_p0);
        out_last <= last_p0;
        if (last_p0) chain_c <= 1'b0;
        else if (arith_p0) chain_c <= carries[WIDTH];
      end
    end
  end

endmodule
